period_meter: RTL and testbench



---
 rtl/period_meter_pkg.sv | 11 +
 rtl/period_meter_edge.sv | 46 ++++
 rtl/period_meter.sv | 126 ++++++++++++
 tb/tb_period_meter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period_meter block.
package period_meter_pkg;

  localparam int unsigned PM_WIDTH_DEFAULT = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pm_state_e;

endpackage

// File: rtl/period_meter_edge.sv
// Edge detector for period_meter; PERIOD_METER_SYNC_EN adds a 2-flop
// synchronizer in front of the edge register so sig_in may be asynchronous.
module period_meter_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic sig_s;
  logic sig_q_r;

`ifdef PERIOD_METER_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-stage synchronizer for an asynchronous sig_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
    end
  end

  assign sig_s = sync2_r;
`else
  assign sig_s = sig_in;
`endif

  // Previous-cycle copy of the signal; reset low so a high input rises at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q_r <= 1'b0;
    end else begin
      sig_q_r <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_q_r;
  assign fall = ~sig_s & sig_q_r;

endmodule

// File: rtl/period_meter.sv
// Period / high-time meter for a slow clk-synchronous square wave.
// Optional input synchronizer selected by PERIOD_METER_SYNC_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH = PM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overflow_o,
  output logic             overrun_o
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  pm_state_e        state_r, state_next_s;
  logic [WIDTH-1:0] cnt_r, cnt_next_s;
  logic [WIDTH-1:0] high_acc_r, high_next_s;
  logic [WIDTH-1:0] period_r, high_r;
  logic             valid_r, overflow_r, overrun_r;
  logic             rise_s, fall_s;
  logic             done_s, ovf_s, load_s, drop_s;

  period_meter_edge u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // FSM next state, counter and high-time capture.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    high_next_s  = high_acc_r;
    done_s       = 1'b0;
    ovf_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          cnt_next_s   = CNT_ONE;
          state_next_s = MEASURE;
        end else begin
          cnt_next_s   = CNT_ZERO;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          done_s     = 1'b1;
          cnt_next_s = CNT_ONE;
        end else if (cnt_r == CNT_MAX) begin
          // Saturated without a rise: abandon this interval entirely.
          ovf_s        = 1'b1;
          cnt_next_s   = CNT_ZERO;
          high_next_s  = CNT_ZERO;
          state_next_s = IDLE;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
          if (fall_s) begin
            high_next_s = cnt_r;
          end else begin
            high_next_s = high_acc_r;
          end
        end
      end
      default: begin
        cnt_next_s   = CNT_ZERO;
        high_next_s  = CNT_ZERO;
        state_next_s = IDLE;
      end
    endcase
    load_s = done_s & (~valid_r | ready_i);
    drop_s = done_s & valid_r & ~ready_i;
  end

  // FSM state, counter and high-time accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      high_acc_r <= CNT_ZERO;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      high_acc_r <= high_next_s;
    end
  end

  // Single-entry result register and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r   <= CNT_ZERO;
      high_r     <= CNT_ZERO;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (load_s) begin
        period_r <= cnt_r;
        high_r   <= high_acc_r;
        valid_r  <= 1'b1;
      end else if (valid_r && ready_i) begin
        valid_r  <= 1'b0;
      end else begin
        valid_r  <= valid_r;
      end
      overflow_r <= ovf_s;
      overrun_r  <= drop_s;
    end
  end

  assign period_o   = period_r;
  assign high_o     = high_r;
  assign valid_o    = valid_r;
  assign overflow_o = overflow_r;
  assign overrun_o  = overrun_r;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: timestamp reference model feeds queues,
// a negedge monitor compares the DUT outputs against them.
module tb_period_meter;

  localparam int TW   = 4;
  localparam int MAXC = (1 << TW) - 1;
`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig_in = 1'b0;
  logic          ready_i = 1'b0;
  logic [TW-1:0] period_o, high_o;
  logic          valid_o, overflow_o, overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  period_meter #(.WIDTH(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period_o   (period_o),
    .high_o     (high_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on absolute cycle timestamps of rises/falls.
  int q_per[$];
  int q_hi[$];
  int t = 0, t0 = 0, thi = 0;
  bit armed = 1'b0, prev = 1'b0, occ = 1'b0, p1 = 1'b0, p2 = 1'b0;
  bit exp_ovf = 1'b0, exp_ovr = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        armed = 1'b0; prev = 1'b0; occ = 1'b0; p1 = 1'b0; p2 = 1'b0;
        exp_ovf = 1'b0; exp_ovr = 1'b0;
        q_per.delete(); q_hi.delete();
      end else begin
        bit s, rise, fall, done, xfer;
        int per, hi;
        t++;
        s  = (LAT == 0) ? sig_in : p2;
        p2 = p1;
        p1 = sig_in;
        rise = s && !prev;
        fall = !s && prev;
        prev = s;
        exp_ovf = 1'b0;
        exp_ovr = 1'b0;
        done = 1'b0;
        per = 0;
        hi = 0;
        if (rise) begin
          if (armed) begin
            done = 1'b1;
            per  = t - t0;
            hi   = thi;
          end
          t0 = t;
          armed = 1'b1;
        end else if (armed) begin
          if (fall) thi = t - t0;
          if (t - t0 == MAXC) begin
            armed = 1'b0;
            exp_ovf = 1'b1;
          end
        end
        xfer = occ && ready_i;
        if (done) begin
          if (!occ || xfer) begin
            q_per.push_back(per);
            q_hi.push_back(hi);
            occ = 1'b1;
          end else begin
            exp_ovr = 1'b1;
          end
        end else if (xfer) begin
          occ = 1'b0;
        end
      end
    end
  end

  // Monitor: compare outputs mid-cycle, retire the head entry on transfer.
  initial begin
    forever begin
      @(negedge clk);
      chk("valid_o", int'(valid_o), int'(occ));
      chk("overflow_o", int'(overflow_o), int'(exp_ovf));
      chk("overrun_o", int'(overrun_o), int'(exp_ovr));
      if (valid_o && occ) begin
        if (q_per.size() == 0) begin
          chk("result_queue_nonempty", 0, 1);
        end else begin
          chk("period_o", int'(period_o), q_per[0]);
          chk("high_o", int'(high_o), q_hi[0]);
        end
      end
      if (occ && ready_i && q_per.size() > 0) begin
        void'(q_per.pop_front());
        void'(q_hi.pop_front());
      end
    end
  end

  task automatic drive(input bit s, input bit r);
    sig_in  = s;
    ready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period_o"}, int'(period_o), 0);
    chk({tag, "_high_o"}, int'(high_o), 0);
    chk({tag, "_valid_o"}, int'(valid_o), 0);
    chk({tag, "_overflow_o"}, int'(overflow_o), 0);
    chk({tag, "_overrun_o"}, int'(overrun_o), 0);
  endtask

  initial begin
    bit lvl;
    int run;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Divide-by-8 source, always ready.
    for (int i = 0; i < 48; i++) drive(((i >> 2) & 1) == 1, 1'b1);
    // Toggle every cycle: minimum period.
    for (int i = 0; i < 20; i++) drive((i % 2) == 0, 1'b1);
    // One rise then low long enough to saturate.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(((i >> 2) & 1) == 1, 1'b1);
    // Back-pressure over several periods, then drain.
    for (int i = 0; i < 30; i++) drive(((i >> 2) & 1) == 1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
    // Random run lengths and random ready.
    lvl = 1'b0;
    for (int i = 0; i < 60; i++) begin
      run = $urandom_range(1, 9);
      lvl = ~lvl;
      for (int k = 0; k < run; k++) drive(lvl, $urandom_range(0, 3) != 0);
    end
    // Reset in the middle of a measurement with a result held.
    for (int i = 0; i < 22; i++) drive(((i >> 2) & 1) == 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    drive(1'b1, 1'b1);
    rst_n = 1'b1;
    for (int i = 1; i < 26; i++) drive(((i >> 2) & 1) == 0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
